// File: rtl/mem_scan_reader_pkg.sv
// Shared types and seven-segment encoding for the memory scan reader.
// Segment codes are active-low, bit order gfedcba.
package mem_scan_reader_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index n holds the glyph for hex digit n (0..F).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib, input logic blank);
        return blank ? SEG_BLANK : SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/mem_scan_reader_key.sv
// Key conditioner: two-flop synchronizer followed by a falling-edge detector.
// One single-cycle pulse per press, no matter how long the key is held.
module key_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic fall_c
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Released key reads as 1, so reset to that level to avoid a spurious pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign fall_c = prev_q & ~sync_q2;

endmodule

// File: rtl/mem_scan_reader.sv
// Walks a small synchronous-read memory one address at a time and shows the
// address and its byte on three seven-segment digits; manual or timed advance.
module mem_scan_reader
    import mem_scan_reader_pkg::*;
#(
    parameter int unsigned DWELL  = 50_000_000,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_n,
    input  logic              auto,
    input  logic              wr_strobe,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [6:0]        hex_addr,
    output logic [6:0]        hex_hi,
    output logic [6:0]        hex_lo,
    output logic              busy
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   addr_next_c;
    logic [DATA_W-1:0]   data_reg;
    logic [DATA_W-1:0]   data_next_c;
    logic [CNT_W-1:0]    dwell_cnt;
    logic                show_q;
    logic                step_c;
    logic                dwell_done_c;
    logic                refresh_c;
    logic                addr_wide_c;

    key_fall_detect u_key (
        .clk    (clk),
        .rst    (rst),
        .key_n  (step_n),
        .fall_c (step_c)
    );

    assign dwell_done_c = auto && (dwell_cnt == CNT_W'(DWELL - 1));
    assign refresh_c    = wr_strobe && (wr_addr == rd_addr);
    assign data_next_c  = (state == ST_WAIT) ? rd_data : data_reg;
    // An address that does not fit in one hex digit blanks the address display.
    assign addr_wide_c  = |(32'(addr_next_c) >> 4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_START;
        end else begin
            state <= next_state;
        end
    end

    // Step beats the dwell timeout, which beats a write-triggered refresh.
    always_comb begin
        next_state  = state;
        addr_next_c = rd_addr;
        case (state)
            ST_START: next_state = ST_FETCH;
            ST_FETCH: next_state = ST_WAIT;
            ST_WAIT:  next_state = ST_SHOW;
            ST_SHOW: begin
                if (step_c || dwell_done_c) begin
                    addr_next_c = rd_addr + ADDR_W'(1);
                    next_state  = ST_FETCH;
                end else if (refresh_c) begin
                    next_state = ST_FETCH;
                end
            end
            default: next_state = ST_START;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b1;
            data_reg  <= '0;
            hex_addr  <= hex_to_seg(4'h0, 1'b0);
            hex_hi    <= hex_to_seg(4'h0, 1'b0);
            hex_lo    <= hex_to_seg(4'h0, 1'b0);
            dwell_cnt <= '0;
            show_q    <= 1'b0;
        end else begin
            rd_en    <= (next_state == ST_FETCH);
            rd_addr  <= addr_next_c;
            busy     <= (next_state != ST_SHOW);
            data_reg <= data_next_c;
            hex_addr <= hex_to_seg(4'(addr_next_c), addr_wide_c);
            hex_hi   <= hex_to_seg(data_next_c[DATA_W-1 -: 4], 1'b0);
            hex_lo   <= hex_to_seg(data_next_c[3:0], 1'b0);
            show_q   <= (state == ST_SHOW);
            // Dwell restarts on every SHOW entry and whenever auto is off.
            if ((state == ST_SHOW) && show_q && auto && !dwell_done_c) begin
                dwell_cnt <= dwell_cnt + CNT_W'(1);
            end else begin
                dwell_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Self-checking bench for mem_scan_reader: reset, stepping, auto dwell,
// write-triggered refresh, step/refresh collisions and reset abort.
module tb_mem_scan_reader;

    localparam int unsigned DWELL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_n;
    logic       auto;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] hex_addr;
    logic [6:0] hex_hi;
    logic [6:0] hex_lo;
    logic       busy;

    always #5 clk = ~clk;

    mem_scan_reader #(.DWELL(DWELL), .ADDR_W(3), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .step_n    (step_n),
        .auto      (auto),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .hex_addr  (hex_addr),
        .hex_hi    (hex_hi),
        .hex_lo    (hex_lo),
        .busy      (busy)
    );

    // Memory: synchronous read, data valid the cycle after rd_en.
    logic [7:0] mem [8];
    always @(posedge clk) if (rd_en === 1'b1) rd_data <= mem[rd_addr];

    logic [6:0] seg_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int   cyc = 0;
    int   rd_cnt = 0;
    int   last_rd_addr = 0;
    int   b2b = 0;
    int   rd_times[$];
    logic rd_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            rd_cnt++;
            last_rd_addr = int'(rd_addr);
            rd_times.push_back(cyc);
            if (rd_prev) b2b++;
        end
        rd_prev = (rd_en === 1'b1);
    end

    int n_chk = 0;
    int n_pass = 0;
    int cur = 0;

    typedef struct {
        int         hold;
        int         exp_addr;
        logic [7:0] exp_data;
    } step_vec_t;

    step_vec_t tbl [8];

    function automatic logic [6:0] seg_of(input int v);
        return seg_t[v & 15];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int hold);
        step_n = 1'b0;
        ticks(hold);
        step_n = 1'b1;
        ticks(8);
    endtask

    task automatic write_word(input int a, input logic [7:0] d);
        mem[a]    = d;
        wr_addr   = 3'(a);
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    task automatic settle_check(input string tag);
        chk({tag, "_rd_addr"}, rd_addr, cur);
        chk({tag, "_hex_addr"}, hex_addr, seg_of(cur));
        chk({tag, "_hex_hi"}, hex_hi, seg_of(int'(mem[cur]) >> 4));
        chk({tag, "_hex_lo"}, hex_lo, seg_of(int'(mem[cur])));
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int a;
        int op;
        logic [7:0] d;
        logic [7:0] old;

        tbl[0] = '{hold: 2,   exp_addr: 1, exp_data: 8'h11};
        tbl[1] = '{hold: 1,   exp_addr: 2, exp_data: 8'h12};
        tbl[2] = '{hold: 5,   exp_addr: 3, exp_data: 8'h13};
        tbl[3] = '{hold: 3,   exp_addr: 4, exp_data: 8'h14};
        tbl[4] = '{hold: 12,  exp_addr: 5, exp_data: 8'h15};
        tbl[5] = '{hold: 2,   exp_addr: 6, exp_data: 8'h16};
        tbl[6] = '{hold: 4,   exp_addr: 7, exp_data: 8'h17};
        tbl[7] = '{hold: 100, exp_addr: 0, exp_data: 8'h10};

        rst = 1'b1; step_n = 1'b1; auto = 1'b0; wr_strobe = 1'b0; wr_addr = '0;
        rd_data = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[0] = 8'h3C;
        ticks(3);

        // Held in reset
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 1);
        chk("rst_hex_addr", hex_addr, 7'h40);
        chk("rst_hex_hi", hex_hi, 7'h40);
        chk("rst_hex_lo", hex_lo, 7'h40);

        // Release: START, FETCH, WAIT, SHOW
        rst = 1'b0;
        chk("c0_rd_en", rd_en, 0);
        tick();
        chk("c1_rd_en", rd_en, 1);
        chk("c1_rd_addr", rd_addr, 0);
        chk("c1_busy", busy, 1);
        tick();
        chk("c2_rd_en", rd_en, 0);
        tick();
        chk("c3_hex_hi", hex_hi, seg_of(3));
        chk("c3_hex_lo", hex_lo, seg_of(12));
        chk("c3_busy", busy, 0);
        ticks(2);

        // Manual stepping through all addresses
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
        for (int i = 0; i < 8; i++) begin
            n0 = rd_cnt;
            press(tbl[i].hold);
            chk("step_rd_count", rd_cnt - n0, 1);
            chk("step_rd_addr", last_rd_addr, tbl[i].exp_addr);
            chk("step_hex_addr", hex_addr, seg_of(tbl[i].exp_addr));
            chk("step_hex_hi", hex_hi, seg_of(int'(tbl[i].exp_data) >> 4));
            chk("step_hex_lo", hex_lo, seg_of(int'(tbl[i].exp_data)));
            cur = tbl[i].exp_addr;
        end

        // Key-to-display latency
        old = mem[cur];
        step_n = 1'b0;
        ticks(2);
        chk("key_k2_rd_en", rd_en, 0);
        tick();
        chk("key_k3_rd_en", rd_en, 1);
        chk("key_k3_rd_addr", rd_addr, (cur + 1) % 8);
        tick();
        chk("key_k4_hex_lo_old", hex_lo, seg_of(int'(old)));
        tick();
        cur = (cur + 1) % 8;
        chk("key_k5_hex_lo_new", hex_lo, seg_of(int'(mem[cur])));
        step_n = 1'b1;
        ticks(4);

        while (cur != 5) begin
            press(2);
            cur = (cur + 1) % 8;
        end
        settle_check("at5");

        // Matching write re-reads and shows new digits at W+3
        old = mem[5];
        n0 = rd_cnt;
        mem[5] = 8'hA7; wr_addr = 3'd5; wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        chk("wr_w1_rd_en", rd_en, 1);
        chk("wr_w1_rd_addr", rd_addr, 5);
        tick();
        chk("wr_w2_hex_hi_old", hex_hi, seg_of(int'(old) >> 4));
        tick();
        chk("wr_w3_hex_hi", hex_hi, seg_of(10));
        chk("wr_w3_hex_lo", hex_lo, seg_of(7));
        ticks(4);
        chk("wr_rd_count", rd_cnt - n0, 1);

        // Non-matching write: no read
        n0 = rd_cnt;
        write_word(2, 8'h55);
        ticks(8);
        chk("wr_other_rd_count", rd_cnt - n0, 0);
        settle_check("wr_other");

        // Step pulse and matching write in the same cycle
        n0 = rd_cnt;
        step_n = 1'b0;
        ticks(2);
        mem[cur] = 8'h5A; wr_addr = 3'(cur); wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        chk("coll_rd_en", rd_en, 1);
        chk("coll_rd_addr", rd_addr, (cur + 1) % 8);
        step_n = 1'b1;
        ticks(8);
        cur = (cur + 1) % 8;
        chk("coll_rd_count", rd_cnt - n0, 1);
        settle_check("coll");

        // Step pulse landing in WAIT is dropped
        n0 = rd_cnt;
        mem[cur] = 8'h6B; wr_addr = 3'(cur); wr_strobe = 1'b1;
        step_n = 1'b0;
        tick();
        wr_strobe = 1'b0;
        ticks(3);
        step_n = 1'b1;
        ticks(8);
        chk("wait_step_rd_count", rd_cnt - n0, 1);
        chk("wait_step_rd_addr", last_rd_addr, cur);
        settle_check("wait_step");

        // Randomized presses and writes against the reference model
        for (int it = 0; it < 40; it++) begin
            n0 = rd_cnt;
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                press(int'($urandom_range(1, 6)));
                cur = (cur + 1) % 8;
                chk("rnd_press_count", rd_cnt - n0, 1);
                chk("rnd_press_addr", last_rd_addr, cur);
            end else begin
                a = (op == 1) ? cur : int'($urandom_range(0, 7));
                d = 8'($urandom);
                write_word(a, d);
                ticks(6);
                chk("rnd_wr_count", rd_cnt - n0, (a == cur) ? 1 : 0);
            end
            settle_check("rnd");
        end

        // Auto mode: rd_en every DWELL+3 cycles
        n0 = rd_cnt;
        auto = 1'b1;
        for (int t = 0; t < 100 && rd_cnt < n0 + 4; t++) tick();
        chk("auto_pulses", rd_cnt - n0, 4);
        if (rd_times.size() >= n0 + 4) begin
            for (int k = 1; k < 4; k++)
                chk("auto_period", rd_times[n0 + k] - rd_times[n0 + k - 1], DWELL + 3);
        end
        cur = (cur + 4) % 8;
        chk("auto_last_addr", last_rd_addr, cur);
        ticks(3);
        auto = 1'b0;
        ticks(30);
        chk("auto_off_frozen", rd_cnt - n0, 4);
        settle_check("auto_off");

        // Reset during WAIT aborts without capturing rd_data
        mem[cur] = 8'hD9; wr_addr = 3'(cur); wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        chk("rstw_fetch", rd_en, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("rstw_rd_en", rd_en, 0);
        chk("rstw_rd_addr", rd_addr, 0);
        chk("rstw_busy", busy, 1);
        chk("rstw_hex_addr", hex_addr, 7'h40);
        chk("rstw_hex_hi", hex_hi, 7'h40);
        chk("rstw_hex_lo", hex_lo, 7'h40);
        rst = 1'b0;
        tick();
        chk("rstw_refetch", rd_en, 1);
        chk("rstw_refetch_addr", rd_addr, 0);
        ticks(6);
        cur = 0;
        settle_check("rstw");

        chk("rd_en_back_to_back", b2b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
